jtag_debug_port: RTL and testbench
==================================

// Module: jtag_debug_port
// PURPOSE
//  Parametrised successor of the single-clock TAP-style debug port. Samples TCK/TMS/TDI through
//  SYNC_STAGES-deep synchronisers, detects TCK edges in the clk domain, and shifts a parametrised
//  instruction register and data register. Shifted values are handed to the MCU with a
//  valid/ready handshake. The MCU reads and writes through split data ports instead of a tristate.
// PARAMETERS
//  INSTR_W         8     instruction register width (>=2); instruction 0 is NOP
//  DATA_W          16    data register width (>=2)
//  SYNC_STAGES     2     synchroniser depth on tck/tms/tdi (>=2)
//  TIMEOUT_CYCLES  4096  clk cycles without a TCK rising edge before abort (JTAG_TIMEOUT_EN only)
// PORTS
//  clk           in   1        system clock
//  rstn          in   1        asynchronous active-low reset
//  tck           in   1        external test clock (async)
//  tms           in   1        external mode select (async)
//  tdi           in   1        external serial data in (async)
//  tdo           out  1        serial data out
//  mcu_wr_en     in   1        MCU loads data register from mcu_wr_data this cycle
//  mcu_wr_data   in   DATA_W   MCU write value
//  mcu_rd_data   out  DATA_W   live data register contents
//  upd_valid     out  1        update pending; upd_instr/upd_data are stable while high
//  upd_ready     in   1        MCU accepts the update
//  upd_instr     out  INSTR_W  instruction latched at Update entry
//  upd_data      out  DATA_W   data latched at Update entry
//  upd_overrun   out  1        1-cycle pulse: new Update arrived while upd_valid was high
//  state_dbg     out  3        current FSM state
// BEHAVIOUR
//  - Reset: state IDLE; instr/data/upd_* regs all 0; tdo, upd_valid and upd_overrun are 0.
//    Synchroniser flops reset to 0, so no TCK edge is seen at reset release.
//  - Edges: tck_rise = synced tck 0->1; tck_fall = synced tck 1->0.
//    Each edge is a 1-clk strobe. All FSM/shift activity occurs only on tck_rise.
//  - FSM encoding and transitions on tck_rise, using synced tms:
//      IDLE 000 / UPDATE 001: tms=0 -> SEL_I;   tms=1 -> IDLE
//      SEL_I  100:            tms=0 -> SHIFT_I; tms=1 -> SEL_D
//      SEL_D  110:            tms=0 -> SHIFT_D; tms=1 -> IDLE
//      SHIFT_I 101:           tms=0 stay;       tms=1 -> UPDATE
//      SHIFT_D 111:           tms=0 stay;       tms=1 -> UPDATE
//  - Shift: on tck_rise in SHIFT_I, instr <= {tdi, instr[INSTR_W-1:1]}.
//    In SHIFT_D, data <= {tdi, data[DATA_W-1:1]}. LSB is shifted first.
//    The exiting edge (tms=1) also shifts.
//  - tdo: registered, updated on tck_fall. Takes data[0] if state[1]=1, else instr[0].
//  - Update entry (tck_rise into UPDATE):
//    upd_instr <= instr and upd_data <= data, using the post-shift values.
//    upd_valid <= 1 on the next clk. If upd_valid was already 1 and upd_ready was not asserted
//    that cycle, regs are overwritten and upd_overrun pulses for 1 cycle.
//  - Leaving UPDATE: on the tck_rise out of UPDATE, instr <= 0 (NOP). Data register is retained.
//  - Handshake: upd_valid clears the cycle after (upd_valid & upd_ready).
//    If accept and a new Update entry fall in the same cycle, upd_valid stays 1 with the new
//    values and there is no overrun.
//  - MCU write: mcu_wr_en loads data <= mcu_wr_data and has priority over a coincident SHIFT_D
//    shift; that shift bit is lost. Write is allowed in any state.
//    mcu_rd_data reflects the new value 1 clk later.
//  - Latency: tck pin to tck_rise strobe is SYNC_STAGES+1 clk. TCK high and low phases must each
//    be >= SYNC_STAGES+2 clk.
// CONFIGURATION
//  JTAG_TIMEOUT_EN defined:
//    - A counter clears on every tck_rise. While state != IDLE it counts clk cycles, saturating.
//    - At TIMEOUT_CYCLES with no tck_rise: state <= IDLE, instr <= 0, data is kept, no Update is
//      issued. A tck_rise in that same cycle wins over the timeout.
//  JTAG_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely. TIMEOUT_CYCLES is unused.
// TESTING
//  1. Reset: rstn=0 mid-SHIFT_D with tck toggling
//     -> state 000, tdo=0, upd_valid=0, all registers 0 until the first post-reset edge.
//  2. Instr load: from IDLE, tms 0,0 then 8 bits of 0xA5 LSB-first, last with tms=1
//     -> UPDATE, upd_instr=0xA5, upd_valid=1. Next edge returns instr to 0.
//  3. Data round trip: mcu_wr_data=0x1234 written, SHIFT_D 16 edges with tdi=0xBEEF
//     -> tdo sequence is 0x1234 LSB-first, upd_data=0xBEEF.
//  4. Overrun: two Updates issued with upd_ready=0
//     -> upd_overrun pulses once, upd_data = second value. Accept and a new Update in the same
//        cycle give no overrun.
//  5. Collision: mcu_wr_en=1 with 0x00FF in the same cycle as a SHIFT_D tck_rise
//     -> data=0x00FF, shift bit dropped.
//  6. JTAG_TIMEOUT_EN, TIMEOUT_CYCLES=64: stall in SHIFT_I for 64 clk
//     -> IDLE, instr=0, upd_valid stays 0. With the macro undefined, state holds SHIFT_I.

Source files
------------

// File: rtl/jtag_debug_port.sv
// rtl/jtag_debug_port.sv - TAP-style debug port: synchronised TCK/TMS/TDI, IR/DR shift, MCU update handshake.
// Optional TCK-stall abort is built when JTAG_TIMEOUT_EN is defined.
module jtag_debug_port #(
  parameter int INSTR_W        = 8,
  parameter int DATA_W         = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tck,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  input  logic               mcu_wr_en,
  input  logic [DATA_W-1:0]  mcu_wr_data,
  output logic [DATA_W-1:0]  mcu_rd_data,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [INSTR_W-1:0] upd_instr,
  output logic [DATA_W-1:0]  upd_data,
  output logic               upd_overrun,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_UPDATE  = 3'b001,
    ST_SEL_I   = 3'b100,
    ST_SHIFT_I = 3'b101,
    ST_SEL_D   = 3'b110,
    ST_SHIFT_D = 3'b111
  } state_e;

  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic                   tck_prev_q, tck_rise_q, tck_fall_q, tms_q, tdi_q;
  logic                   tck_s;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 tdo_q, tdo_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [INSTR_W-1:0]   upd_instr_q, upd_instr_d;
  logic [DATA_W-1:0]    upd_data_q, upd_data_d;
  logic                 upd_overrun_q, upd_overrun_d;
  logic                 upd_entry;
  logic                 timeout_hit;

  assign tck_s = tck_sync_q[SYNC_STAGES-1];

  // Strobes are registered so tms/tdi are re-timed to line up with them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
      tck_rise_q <= 1'b0;
      tck_fall_q <= 1'b0;
      tms_q      <= 1'b0;
      tdi_q      <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], tck};
      tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
      tck_prev_q <= tck_s;
      tck_rise_q <= tck_s & ~tck_prev_q;
      tck_fall_q <= ~tck_s & tck_prev_q;
      tms_q      <= tms_sync_q[SYNC_STAGES-1];
      tdi_q      <= tdi_sync_q[SYNC_STAGES-1];
    end
  end

`ifdef JTAG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (tck_rise_q || state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LIMIT) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_LIMIT) && !tck_rise_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    data_d        = data_q;
    upd_entry     = 1'b0;
    tdo_d         = tdo_q;
    upd_valid_d   = upd_valid_q;
    upd_instr_d   = upd_instr_q;
    upd_data_d    = upd_data_q;
    upd_overrun_d = 1'b0;

    if (tck_rise_q) begin
      unique case (state_q)
        ST_IDLE, ST_UPDATE: state_d = tms_q ? ST_IDLE  : ST_SEL_I;
        ST_SEL_I:           state_d = tms_q ? ST_SEL_D : ST_SHIFT_I;
        ST_SEL_D:           state_d = tms_q ? ST_IDLE  : ST_SHIFT_D;
        ST_SHIFT_I: begin
          instr_d = {tdi_q, instr_q[INSTR_W-1:1]};
          if (tms_q) begin
            state_d   = ST_UPDATE;
            upd_entry = 1'b1;
          end
        end
        ST_SHIFT_D: begin
          data_d = {tdi_q, data_q[DATA_W-1:1]};
          if (tms_q) begin
            state_d   = ST_UPDATE;
            upd_entry = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_q == ST_UPDATE) begin
        instr_d = '0;
      end
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
      instr_d = '0;
    end

    // Post-shift data is captured even if the MCU overwrites the register this cycle.
    if (upd_entry) begin
      upd_valid_d   = 1'b1;
      upd_instr_d   = instr_d;
      upd_data_d    = data_d;
      upd_overrun_d = upd_valid_q & ~upd_ready;
    end else if (upd_valid_q && upd_ready) begin
      upd_valid_d = 1'b0;
    end

    if (mcu_wr_en) begin
      data_d = mcu_wr_data;
    end

    if (tck_fall_q) begin
      tdo_d = state_q[1] ? data_q[0] : instr_q[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instr_q       <= '0;
      data_q        <= '0;
      tdo_q         <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_instr_q   <= '0;
      upd_data_q    <= '0;
      upd_overrun_q <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      data_q        <= data_d;
      tdo_q         <= tdo_d;
      upd_valid_q   <= upd_valid_d;
      upd_instr_q   <= upd_instr_d;
      upd_data_q    <= upd_data_d;
      upd_overrun_q <= upd_overrun_d;
    end
  end

  assign tdo         = tdo_q;
  assign mcu_rd_data = data_q;
  assign upd_valid   = upd_valid_q;
  assign upd_instr   = upd_instr_q;
  assign upd_data    = upd_data_q;
  assign upd_overrun = upd_overrun_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_jtag_debug_port.sv
// tb/tb_jtag_debug_port.sv - scoreboard bench for jtag_debug_port with a transaction-level scan model.
module tb_jtag_debug_port;
  localparam int IW   = 8;
  localparam int DW   = 16;
  localparam int SS   = 2;
  localparam int TO   = 64;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic          tdo;
  logic          mcu_wr_en = 1'b0;
  logic [DW-1:0] mcu_wr_data = '0;
  logic [DW-1:0] mcu_rd_data;
  logic          upd_valid;
  logic          upd_ready = 1'b0;
  logic [IW-1:0] upd_instr;
  logic [DW-1:0] upd_data;
  logic          upd_overrun;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  jtag_debug_port #(.INSTR_W(IW), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .mcu_wr_en(mcu_wr_en), .mcu_wr_data(mcu_wr_data), .mcu_rd_data(mcu_rd_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_instr(upd_instr),
    .upd_data(upd_data), .upd_overrun(upd_overrun), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [IW-1:0] i;
    logic [DW-1:0] d;
  } upd_t;

  upd_t          exp_q[$];
  upd_t          mon_e;
  int            total = 0;
  int            bad = 0;
  int            exp_ovr = 0;
  int            seen_ovr = 0;
  logic [IW-1:0] m_instr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge values are what the next edge consumes.
  always @(negedge clk) begin
    if (rstn) begin
      if (upd_overrun) seen_ovr++;
      if (upd_valid && upd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL upd_unexpected: got %0h/%0h want none", upd_instr, upd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("upd_instr", 32'(upd_instr), 32'(mon_e.i));
          chk("upd_data", 32'(upd_data), 32'(mon_e.d));
        end
      end
    end
  end

  task automatic push_exp(input logic [IW-1:0] i, input logic [DW-1:0] d, input logic coll);
    upd_t e;
    if (!coll && !upd_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      exp_ovr++;
    end
    e.i = i;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, input logic rdy_p,
                           input logic wr_p, output logic tdo_s);
    @(posedge clk); #1;
    tms = tms_v;
    tdi = tdi_v;
    repeat (HALF) @(posedge clk);
    #1;
    tdo_s = tdo;
    tck = 1'b1;
    if (rdy_p || wr_p) begin
      repeat (SS + 1) @(posedge clk);
      #1;
      if (rdy_p) upd_ready = 1'b1;
      if (wr_p) mcu_wr_en = 1'b1;
      @(posedge clk); #1;
      if (rdy_p) upd_ready = 1'b0;
      mcu_wr_en = 1'b0;
      repeat (HALF - SS - 2) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1;
    tck = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ir_scan(input logic [IW-1:0] v, input logic coll);
    logic t;
    m_instr = '0;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < IW; i++) begin
      if (i == IW - 1) push_exp(v, m_data, coll);
      tck_cycle(i == IW - 1, v[i], (i == IW - 1) && coll, 1'b0, t);
      chk("ir_tdo", 32'(t), 32'(m_instr[i]));
    end
    m_instr = v;
  endtask

  task automatic dr_enter();
    logic t;
    m_instr = '0;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic dr_body(input logic [DW-1:0] d, input logic coll);
    logic t;
    for (int i = 0; i < DW; i++) begin
      if (i == DW - 1) push_exp(m_instr, d, coll);
      tck_cycle(i == DW - 1, d[i], (i == DW - 1) && coll, 1'b0, t);
      chk("dr_tdo", 32'(t), 32'(m_data[i]));
    end
    m_data = d;
  endtask

  task automatic mcu_write(input logic [DW-1:0] v);
    @(posedge clk); #1;
    mcu_wr_en   = 1'b1;
    mcu_wr_data = v;
    @(posedge clk); #1;
    mcu_wr_en = 1'b0;
    chk("mcu_rd", 32'(mcu_rd_data), 32'(v));
    m_data = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic t;
    logic [IW-1:0] a_i;
    logic [DW-1:0] b_d;

    idle_clks(5);
    rstn = 1'b1;
    idle_clks(2);
    chk("rst_state", 32'(state_dbg), 32'h0);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_valid", 32'(upd_valid), 32'h0);
    chk("rst_rd", 32'(mcu_rd_data), 32'h0);
    chk("rst_uinstr", 32'(upd_instr), 32'h0);
    chk("rst_udata", 32'(upd_data), 32'h0);

    // reset asserted mid SHIFT_D with tck still toggling
    dr_enter();
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, t);
    chk("in_shift_d", 32'(state_dbg), 32'h7);
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (HALF) @(posedge clk);
      #1;
      tck = ~tck;
    end
    chk("rst2_state", 32'(state_dbg), 32'h0);
    chk("rst2_tdo", 32'(tdo), 32'h0);
    chk("rst2_valid", 32'(upd_valid), 32'h0);
    chk("rst2_rd", 32'(mcu_rd_data), 32'h0);
    rstn = 1'b1;
    idle_clks(10);
    chk("rel_state", 32'(state_dbg), 32'h0);
    m_data  = '0;
    m_instr = '0;

    // instruction load held pending
    ir_scan(8'hA5, 1'b0);
    chk("ir_state_upd", 32'(state_dbg), 32'h1);
    chk("ir_valid", 32'(upd_valid), 32'h1);
    chk("ir_uinstr", 32'(upd_instr), 32'hA5);
    upd_ready = 1'b1;
    idle_clks(3);
    chk("ir_valid_clr", 32'(upd_valid), 32'h0);

    // data round trip
    mcu_write(16'h1234);
    dr_enter();
    dr_body(16'hBEEF, 1'b0);
    idle_clks(4);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        ir_scan(IW'($urandom), 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) mcu_write(DW'($urandom));
        dr_enter();
        dr_body(DW'($urandom), 1'b0);
      end
      idle_clks(4);
    end

    // overrun, then accept coinciding with a new update
    upd_ready = 1'b0;
    a_i = IW'($urandom);
    b_d = DW'($urandom);
    ir_scan(a_i, 1'b0);
    dr_enter();
    dr_body(b_d, 1'b0);
    idle_clks(3);
    chk("ovr_udata", 32'(upd_data), 32'(b_d));
    chk("ovr_valid", 32'(upd_valid), 32'h1);
    a_i = IW'($urandom);
    ir_scan(a_i, 1'b1);
    idle_clks(3);
    chk("acc_valid", 32'(upd_valid), 32'h1);
    chk("acc_uinstr", 32'(upd_instr), 32'(a_i));
    upd_ready = 1'b1;
    idle_clks(4);

    // MCU write collides with a SHIFT_D edge
    dr_enter();
    @(posedge clk); #1;
    mcu_wr_data = 16'h00FF;
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b1, t);
    chk("coll_rd", 32'(mcu_rd_data), 32'h00FF);
    m_data = 16'h00FF;
    dr_body(DW'($urandom), 1'b0);
    idle_clks(4);

    // stall inside SHIFT_I
    m_instr = '0;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, t);
    idle_clks(TO + 16);
`ifdef JTAG_TIMEOUT_EN
    chk("stall_state", 32'(state_dbg), 32'h0);
`else
    chk("stall_state", 32'(state_dbg), 32'h5);
`endif
    chk("stall_valid", 32'(upd_valid), 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("overruns", 32'(seen_ovr), 32'(exp_ovr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
